iq_mixer: RTL and testbench

IQ_MIXER -- requirements
Module: iq_mixer

---
 rtl/iq_mixer.sv | 135 +++++++++++++
 tb/tb_iq_mixer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/iq_mixer.sv
// IQ mixer: multiplies the real ADC stream by the LO cosine/sine, then rounds and
// saturates each product to the I/Q output width over three CE-qualified stages.
module iq_mixer #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         sample_clk_ce,
  input  logic signed [DATA_WIDTH-1:0] adc_in,
  input  logic signed [DATA_WIDTH-1:0] sinewave,
  input  logic signed [DATA_WIDTH-1:0] cosinewave,
  input  logic                         sat_clear,
  output logic signed [OUT_WIDTH-1:0]  i_out,
  output logic signed [OUT_WIDTH-1:0]  q_out,
  output logic                         out_valid,
  output logic                         i_sat,
  output logic                         q_sat
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PROD_W + 1;
  localparam int SHIFT  = 2 * DATA_WIDTH - OUT_WIDTH - 1;

  // One rounding constant covers both the Q-format shift and the output-width reduction
  localparam logic signed [SUM_W-1:0] ROUND_K =
    $signed({{(SUM_W-1){1'b0}}, 1'b1} << (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    $signed({{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    $signed({{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  logic signed [DATA_WIDTH-1:0] adc_q, adc_d;
  logic signed [DATA_WIDTH-1:0] sin_q, sin_d;
  logic signed [DATA_WIDTH-1:0] cos_q, cos_d;
  logic signed [PROD_W-1:0]     pi_q, pi_d;
  logic signed [PROD_W-1:0]     pq_q, pq_d;
  logic signed [OUT_WIDTH-1:0]  i_out_q, i_out_d;
  logic signed [OUT_WIDTH-1:0]  q_out_q, q_out_d;
  logic                         out_valid_q, out_valid_d;
  logic                         i_sat_q, i_sat_d;
  logic                         q_sat_q, q_sat_d;
  logic [1:0]                   fill_q, fill_d;

  logic signed [SUM_W-1:0]      i_round;
  logic signed [SUM_W-1:0]      q_round;
  logic                         i_clip;
  logic                         q_clip;

  function automatic logic signed [SUM_W-1:0] round_shift(input logic signed [PROD_W-1:0] p);
    logic signed [SUM_W-1:0] sum;
    sum = $signed({p[PROD_W-1], p}) + ROUND_K;
    return sum >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [SUM_W-1:0] r);
    logic signed [SUM_W-1:0] v;
    if (r > SAT_MAX) begin
      v = SAT_MAX;
    end else if (r < SAT_MIN) begin
      v = SAT_MIN;
    end else begin
      v = r;
    end
    return v[OUT_WIDTH-1:0];
  endfunction

  always_comb begin
    adc_d       = adc_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
    pi_d        = pi_q;
    pq_d        = pq_q;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    fill_d      = fill_q;
    i_round     = round_shift(pi_q);
    q_round     = round_shift(pq_q);
    i_clip      = (i_round > SAT_MAX) || (i_round < SAT_MIN);
    q_clip      = (q_round > SAT_MAX) || (q_round < SAT_MIN);
    out_valid_d = sample_clk_ce && fill_q[1];

    if (sample_clk_ce) begin
      adc_d   = adc_in;
      sin_d   = sinewave;
      cos_d   = cosinewave;
      pi_d    = PROD_W'(adc_q) * PROD_W'(cos_q);
      pq_d    = PROD_W'(adc_q) * PROD_W'(sin_q);
      i_out_d = saturate(i_round);
      q_out_d = saturate(q_round);
      if (fill_q != 2'd3) begin
        fill_d = fill_q + 2'd1;
      end
    end

    // A clip on the same edge as a clear must leave the flag set
    i_sat_d = (sample_clk_ce && i_clip) ? 1'b1 : (sat_clear ? 1'b0 : i_sat_q);
    q_sat_d = (sample_clk_ce && q_clip) ? 1'b1 : (sat_clear ? 1'b0 : q_sat_q);
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      adc_q       <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      pi_q        <= '0;
      pq_q        <= '0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
      i_sat_q     <= 1'b0;
      q_sat_q     <= 1'b0;
      fill_q      <= '0;
    end else begin
      adc_q       <= adc_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      pi_q        <= pi_d;
      pq_q        <= pq_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
      i_sat_q     <= i_sat_d;
      q_sat_q     <= q_sat_d;
      fill_q      <= fill_d;
    end
  end

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = out_valid_q;
  assign i_sat     = i_sat_q;
  assign q_sat     = q_sat_q;

endmodule

// File: tb/tb_iq_mixer.sv
// Directed + randomised bench for iq_mixer; a scoreboard queue carries expected
// I/Q results from the edge a sample enters the pipeline to the edge it emerges.
module tb_iq_mixer;

  logic               clk = 1'b0;
  logic               arst = 1'b1;
  logic               sample_clk_ce = 1'b0;
  logic signed [15:0] adc_in = '0;
  logic signed [15:0] sinewave = '0;
  logic signed [15:0] cosinewave = '0;
  logic               sat_clear = 1'b0;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic               out_valid;
  logic               i_sat;
  logic               q_sat;

  typedef struct {
    logic signed [15:0] i_val;
    logic signed [15:0] q_val;
    bit                 clip_i;
    bit                 clip_q;
  } item_t;

  item_t              sb[$];
  int                 vectors = 0;
  int                 miscompares = 0;
  int                 exp_fill = 0;
  logic               exp_valid = 1'b0;
  logic signed [15:0] exp_i = '0;
  logic signed [15:0] exp_q = '0;
  logic               exp_i_sat = 1'b0;
  logic               exp_q_sat = 1'b0;

  iq_mixer #(.DATA_WIDTH(16), .OUT_WIDTH(16)) dut (
    .clk          (clk),
    .arst         (arst),
    .sample_clk_ce(sample_clk_ce),
    .adc_in       (adc_in),
    .sinewave     (sinewave),
    .cosinewave   (cosinewave),
    .sat_clear    (sat_clear),
    .i_out        (i_out),
    .q_out        (q_out),
    .out_valid    (out_valid),
    .i_sat        (i_sat),
    .q_sat        (q_sat)
  );

  always #5 clk = ~clk;

  // Q1.15 x Q1.15 product, round half-up back to Q1.15, clip to 16 bits
  task automatic round_sat(input longint p, output logic signed [15:0] r, output bit clip);
    longint t;
    t = (p + 64'sd16384) >>> 15;
    clip = 1'b0;
    if (t > 32767) begin
      t = 32767;
      clip = 1'b1;
    end else if (t < -32768) begin
      t = -32768;
      clip = 1'b1;
    end
    r = 16'(t);
  endtask

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input bit ce, input int a, input int s, input int c,
                                input bit clr, input bit rst);
    item_t  it;
    bit     popped;
    longint a_l;
    a_l = longint'(a);
    sample_clk_ce = ce;
    adc_in        = 16'(a);
    sinewave      = 16'(s);
    cosinewave    = 16'(c);
    sat_clear     = clr;
    arst          = rst;
    @(posedge clk);
    popped = 1'b0;
    if (rst) begin
      exp_fill  = 0;
      exp_valid = 1'b0;
      exp_i     = '0;
      exp_q     = '0;
      exp_i_sat = 1'b0;
      exp_q_sat = 1'b0;
      sb.delete();
    end else begin
      exp_valid = ce && (exp_fill >= 2);
      if (ce) begin
        round_sat(a_l * longint'(c), it.i_val, it.clip_i);
        round_sat(a_l * longint'(s), it.q_val, it.clip_q);
        sb.push_back(it);
        if (exp_fill >= 2 && sb.size() > 0) begin
          it     = sb.pop_front();
          popped = 1'b1;
          exp_i  = it.i_val;
          exp_q  = it.q_val;
        end
        if (exp_fill < 3) exp_fill++;
      end
      exp_i_sat = (popped && it.clip_i) ? 1'b1 : (clr ? 1'b0 : exp_i_sat);
      exp_q_sat = (popped && it.clip_q) ? 1'b1 : (clr ? 1'b0 : exp_q_sat);
    end
    #1;
    check_output("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    check_output("i_out", i_out, exp_i);
    check_output("q_out", q_out, exp_q);
    check_output("i_sat", {31'd0, i_sat}, {31'd0, exp_i_sat});
    check_output("q_sat", {31'd0, q_sat}, {31'd0, exp_q_sat});
  endtask

  initial begin
    $display("[TB] reset with CE high");
    apply_stimulus(1, 1234, 555, -777, 1, 1);
    apply_stimulus(1, 1234, 555, -777, 1, 1);
    check_output("reset_i_out", i_out, 0);
    check_output("reset_valid", {31'd0, out_valid}, 0);

    $display("[TB] nominal multiply");
    for (int k = 0; k < 4; k++) apply_stimulus(1, 16384, 0, 32767, 0, 0);
    check_output("nominal_i", i_out, 16384);
    check_output("nominal_q", q_out, 0);

    $display("[TB] rounding");
    apply_stimulus(1, 1, 0, 16384, 0, 0);
    apply_stimulus(1, -1, 0, 16384, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("round_pos", i_out, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("round_neg", i_out, 0);

    $display("[TB] saturation and sticky flags");
    apply_stimulus(1, -32768, -32768, 0, 0, 0);
    apply_stimulus(1, 100, 200, 300, 0, 0);
    apply_stimulus(1, 100, 200, 300, 0, 0);
    check_output("sat_q_out", q_out, 32767);
    check_output("sat_q_flag", {31'd0, q_sat}, 1);
    apply_stimulus(1, 100, 200, 300, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("sat_sticky", {31'd0, q_sat}, 1);
    apply_stimulus(1, 100, 200, 300, 1, 0);
    check_output("sat_cleared", {31'd0, q_sat}, 0);
    apply_stimulus(1, -32768, -32768, -32768, 0, 0);
    apply_stimulus(1, 10, 20, 30, 0, 0);
    apply_stimulus(1, 10, 20, 30, 1, 0);
    check_output("sat_set_wins_q", {31'd0, q_sat}, 1);
    check_output("sat_set_wins_i", {31'd0, i_sat}, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    check_output("sat_clear_no_ce", {31'd0, i_sat}, 0);

    $display("[TB] CE every 4th clock");
    for (int k = 0; k < 12; k++) begin
      apply_stimulus(1, int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768, 0, 0);
      for (int j = 0; j < 3; j++) apply_stimulus(0, 7, 7, 7, 0, 0);
    end

    $display("[TB] mid-stream reset");
    for (int k = 0; k < 5; k++) apply_stimulus(1, 1000 * k, 3000, -2000, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 1);
    apply_stimulus(1, 5000, 6000, 7000, 0, 0);
    apply_stimulus(1, 5001, 6001, 7001, 0, 0);
    check_output("post_reset_2ce", {31'd0, out_valid}, 0);
    apply_stimulus(1, 5002, 6002, 7002, 0, 0);
    check_output("post_reset_3ce", {31'd0, out_valid}, 1);
    check_output("post_reset_i", i_out, 1068);

    $display("[TB] random mix");
    for (int k = 0; k < 60; k++) begin
      apply_stimulus(1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768,
                     ($urandom_range(0, 7) == 0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
